// File: rtl/seg_scan_if.sv
// Digit/control inputs and display outputs of the 7-segment scan driver.
interface seg_scan_if;
  logic [3:0] i_dig0;
  logic [3:0] i_dig1;
  logic [3:0] i_dig2;
  logic [3:0] i_dig3;
  logic       i_lz_en;
  logic [3:0] i_blink_mask;
  logic       i_colon_en;
  logic [6:0] o_seg;
  logic [3:0] o_an;
  logic       o_dp;
  logic       o_frame_start;

  modport master (
    output i_dig0, i_dig1, i_dig2, i_dig3, i_lz_en, i_blink_mask, i_colon_en,
    input  o_seg, o_an, o_dp, o_frame_start
  );

  modport slave (
    input  i_dig0, i_dig1, i_dig2, i_dig3, i_lz_en, i_blink_mask, i_colon_en,
    output o_seg, o_an, o_dp, o_frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit common-anode 7-segment scan driver: per-frame snapshot of the digits,
// ghosting guard at the start of each slot, leading-zero blanking, blink, colon.
module seg_scan_driver #(
  parameter int CLK_DIV      = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  seg_scan_if.slave   s_if
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]       r_cnt;
  logic [1:0]          r_slot;
  logic [3:0][3:0]     r_sh_dig;
  logic                r_sh_lz;
  logic [3:0]          r_sh_mask;
  logic                r_sh_colon;
  logic [FW-1:0]       r_frm;
  logic                r_phase;
  logic                r_snap_q;
  logic [3:0]          r_an;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic                r_fs;

  logic                w_wrap;
  logic                w_snap;
  logic                w_in_guard;
  logic                w_en;
  logic [3:0]          w_dig;

  assign w_wrap = (r_cnt == CW'(CLK_DIV - 1));
  assign w_snap = w_wrap && (r_slot == 2'd3);

  // Guard comparison only exists when a guard is configured.
  generate
    if (GUARD == 0) begin : g_noguard
      assign w_in_guard = 1'b0;
    end else begin : g_guard
      assign w_in_guard = (r_cnt < CW'(GUARD));
    end
  endgenerate

  assign w_dig = r_sh_dig[r_slot];
  assign w_en  = !w_in_guard
              && !((r_slot == 2'd3) && r_sh_lz && (r_sh_dig[3] == 4'd0))
              && !(r_phase && r_sh_mask[r_slot]);

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = 7'b1111111;
    endcase
  endfunction

  // Prescaler and slot counter: slot advances on prescaler wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_slot <= 2'd0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_slot <= r_slot + 2'd1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Shadow capture at the end of slot 3 so a frame never mixes old and new digits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh_dig   <= '0;
      r_sh_lz    <= 1'b0;
      r_sh_mask  <= 4'd0;
      r_sh_colon <= 1'b0;
    end else if (w_snap) begin
      r_sh_dig   <= {s_if.i_dig3, s_if.i_dig2, s_if.i_dig1, s_if.i_dig0};
      r_sh_lz    <= s_if.i_lz_en;
      r_sh_mask  <= s_if.i_blink_mask;
      r_sh_colon <= s_if.i_colon_en;
    end
  end

  // Frame counter and blink phase, stepped once per snapshot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frm    <= '0;
      r_phase  <= 1'b0;
      r_snap_q <= 1'b0;
    end else begin
      r_snap_q <= w_snap;
      if (w_snap) begin
        if (r_frm == FW'(BLINK_FRAMES - 1)) begin
          r_frm   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frm   <= r_frm + FW'(1);
        end
      end
    end
  end

  // Registered outputs; frame_start lines up with the first output cycle of slot 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
      r_fs  <= 1'b0;
    end else begin
      r_an  <= w_en ? ~(4'b0001 << r_slot) : 4'hF;
      r_seg <= w_en ? f_decode(w_dig) : 7'h7F;
      r_dp  <= ~(w_en && (r_slot == 2'd2) && r_sh_colon);
      r_fs  <= r_snap_q;
    end
  end

  assign s_if.o_an          = r_an;
  assign s_if.o_seg         = r_seg;
  assign s_if.o_dp          = r_dp;
  assign s_if.o_frame_start = r_fs;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: elapsed-time reference model checked every cycle,
// a vector table for decode/blanking cases, and hand sequences for reset and blink.
module tb_seg_scan_driver;
  localparam int CD = 8;
  localparam int G  = 2;
  localparam int BF = 2;
  localparam int FL = 4 * CD;

  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } out_t;

  typedef struct {
    logic [15:0] dig;
    logic        lz;
    logic        colon;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] r_d [4];
  logic r_lz, r_colon;
  logic [3:0] r_mask;
  int ntest = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seg_scan_if ifa ();
  seg_scan_if ifb ();

  assign ifa.i_dig0 = r_d[0];
  assign ifa.i_dig1 = r_d[1];
  assign ifa.i_dig2 = r_d[2];
  assign ifa.i_dig3 = r_d[3];
  assign ifa.i_lz_en = r_lz;
  assign ifa.i_blink_mask = r_mask;
  assign ifa.i_colon_en = r_colon;

  assign ifb.i_dig0 = r_d[0];
  assign ifb.i_dig1 = r_d[1];
  assign ifb.i_dig2 = r_d[2];
  assign ifb.i_dig3 = r_d[3];
  assign ifb.i_lz_en = 1'b0;
  assign ifb.i_blink_mask = 4'd0;
  assign ifb.i_colon_en = r_colon;

  seg_scan_driver #(.CLK_DIV(CD), .GUARD(G), .BLINK_FRAMES(BF)) dut_a (
    .i_clk(clk), .i_rst(rst), .s_if(ifa));

  seg_scan_driver #(.CLK_DIV(4), .GUARD(0), .BLINK_FRAMES(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .s_if(ifb));

  // ---------------- reference model ----------------
  int         m_p = 0;
  int         m_n = 0;
  logic [3:0] m_dig [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic       m_lz = 1'b0, m_colon = 1'b0;
  logic [3:0] m_mask = 4'd0;
  out_t       e = '{4'hF, 7'h7F, 1'b1, 1'b0};

  // Output seen after the edge that ends elapsed cycle p, given n snapshots so far.
  function automatic out_t mdl(int p, int n);
    out_t o;
    int c, s;
    bit en;
    c  = p % CD;
    s  = (p / CD) % 4;
    en = (c >= G) && !(s == 3 && m_lz && m_dig[3] == 4'd0)
         && !(((n / BF) % 2) == 1 && m_mask[s]);
    o.an  = en ? 4'(~(4'd1 << s)) : 4'hF;
    o.seg = en ? DEC[m_dig[s]] : 7'h7F;
    o.dp  = !(en && s == 2 && m_colon);
    o.fs  = (p % FL == 0) && (p != 0);
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p <= 0;
      m_n <= 0;
      m_lz <= 1'b0;
      m_colon <= 1'b0;
      m_mask <= 4'd0;
      for (int i = 0; i < 4; i++) m_dig[i] <= 4'd0;
      e <= '{4'hF, 7'h7F, 1'b1, 1'b0};
    end else begin
      e <= mdl(m_p, m_n);
      if (m_p % FL == FL - 1) begin
        for (int i = 0; i < 4; i++) m_dig[i] <= r_d[i];
        m_lz <= r_lz;
        m_colon <= r_colon;
        m_mask <= r_mask;
        m_n <= m_n + 1;
      end
      m_p <= m_p + 1;
    end
  end

  // Every-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      ntest++;
      if ({ifa.o_an, ifa.o_seg, ifa.o_dp, ifa.o_frame_start} !== e) begin
        nfail++;
        $display("FAIL model p=%0d got an=%b seg=%b dp=%b fs=%b want an=%b seg=%b dp=%b fs=%b",
                 m_p, ifa.o_an, ifa.o_seg, ifa.o_dp, ifa.o_frame_start,
                 e.an, e.seg, e.dp, e.fs);
      end
    end
  end

  // Instance B has no guard and no suppression: exactly one anode low every cycle.
  int bcnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) bcnt <= 0;
    else if (bcnt < 2) bcnt <= bcnt + 1;
  end

  always @(negedge clk) begin
    if (chk_en && !rst && bcnt >= 1) begin
      ntest++;
      if ($countones(~ifb.o_an) != 1) begin
        nfail++;
        $display("FAIL noguard_onehot got an=%b want exactly one low bit", ifb.o_an);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ifa.o_frame_start && k < 200);
    chk("wait_frame_start", {31'd0, ifa.o_frame_start}, 32'd1);
  endtask

  vec_t tbl [10];

  initial begin
    int j, k;
    tbl[0] = '{16'h4321, 1'b0, 1'b0, 0, 4'b1110, 7'b1111001, 1'b1};
    tbl[1] = '{16'h4321, 1'b0, 1'b0, 1, 4'b1101, 7'b0100100, 1'b1};
    tbl[2] = '{16'h4321, 1'b0, 1'b0, 2, 4'b1011, 7'b0110000, 1'b1};
    tbl[3] = '{16'h4321, 1'b0, 1'b0, 3, 4'b0111, 7'b0011001, 1'b1};
    tbl[4] = '{16'h00A0, 1'b0, 1'b0, 1, 4'b1101, 7'b1111111, 1'b1};
    tbl[5] = '{16'h0999, 1'b1, 1'b0, 3, 4'hF,    7'h7F,      1'b1};
    tbl[6] = '{16'h5999, 1'b1, 1'b0, 3, 4'b0111, 7'b0010010, 1'b1};
    tbl[7] = '{16'h0678, 1'b1, 1'b1, 2, 4'b1011, 7'b0000010, 1'b0};
    tbl[8] = '{16'h0123, 1'b0, 1'b0, 3, 4'b0111, 7'b1000000, 1'b1};
    tbl[9] = '{16'h8769, 1'b0, 1'b1, 0, 4'b1110, 7'b0010000, 1'b1};

    for (int i = 0; i < 4; i++) r_d[i] = 4'd0;
    r_lz = 1'b0; r_colon = 1'b0; r_mask = 4'd0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    r_d[3] = 4'd1; r_d[2] = 4'd2; r_d[1] = 4'd3; r_d[0] = 4'd4;
    repeat (70) @(negedge clk);

    // Reset in the middle of slot 1, then blink/colon sequence from a clean start.
    k = 0;
    while (ifa.o_an != 4'b1101 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("find_an_1101", {28'd0, ifa.o_an}, 32'hD);
    #2 rst = 1'b1;
    #1;
    chk("rst_an", {28'd0, ifa.o_an}, 32'hF);
    chk("rst_seg", {25'd0, ifa.o_seg}, 32'h7F);
    chk("rst_dp", {31'd0, ifa.o_dp}, 32'd1);
    chk("rst_fs", {31'd0, ifa.o_frame_start}, 32'd0);
    r_mask = 4'b0001; r_colon = 1'b1; r_lz = 1'b0;
    r_d[3] = 4'd7; r_d[2] = 4'd6; r_d[1] = 4'd5; r_d[0] = 4'd4;
    @(negedge clk);
    rst = 1'b0;
    j = 0;
    @(negedge clk); j++;
    chk("post_rst_guard0", {28'd0, ifa.o_an}, 32'hF);
    @(negedge clk); j++;
    chk("post_rst_guard1", {28'd0, ifa.o_an}, 32'hF);
    @(negedge clk); j++;
    chk("post_rst_an", {28'd0, ifa.o_an}, 32'hE);
    chk("post_rst_seg", {25'd0, ifa.o_seg}, 32'h40);
    for (int f = 0; f < 5; f++) begin
      while (j < f * FL + 5) begin @(negedge clk); j++; end
      chk($sformatf("blink_f%0d_an0", f), {31'd0, ifa.o_an[0]}, (f == 2 || f == 3) ? 32'd1 : 32'd0);
      while (j < f * FL + 17) begin @(negedge clk); j++; end
      chk($sformatf("colon_guard_f%0d", f), {31'd0, ifa.o_dp}, 32'd1);
      while (j < f * FL + 21) begin @(negedge clk); j++; end
      chk($sformatf("colon_f%0d", f), {31'd0, ifa.o_dp}, (f == 0) ? 32'd1 : 32'd0);
    end

    // Vector table: each row is made visible by one snapshot, then sampled mid-slot.
    r_mask = 4'd0;
    for (int i = 0; i < 10; i++) begin
      r_d[3] = tbl[i].dig[15:12]; r_d[2] = tbl[i].dig[11:8];
      r_d[1] = tbl[i].dig[7:4];   r_d[0] = tbl[i].dig[3:0];
      r_lz = tbl[i].lz; r_colon = tbl[i].colon;
      wait_fs();
      repeat (tbl[i].slot * CD + 5) @(negedge clk);
      chk($sformatf("vec%0d_an", i), {28'd0, ifa.o_an}, {28'd0, tbl[i].an});
      chk($sformatf("vec%0d_seg", i), {25'd0, ifa.o_seg}, {25'd0, tbl[i].seg});
      chk($sformatf("vec%0d_dp", i), {31'd0, ifa.o_dp}, {31'd0, tbl[i].dp});
    end

    // Random input churn at arbitrary points in the frame.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        for (int i = 0; i < 4; i++) r_d[i] = 4'($urandom_range(15));
        r_lz = 1'($urandom_range(1));
        r_colon = 1'($urandom_range(1));
        r_mask = 4'($urandom_range(15));
        if ($urandom_range(1) == 0) r_d[3] = 4'd0;
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
